tag_lookup_ctrl: RTL and testbench

Sequencing controller for the instruction-cache tag array (16 rows x 32 bits, 4 byte-wide blocks per row).
- Accepts fetch lookup requests, issues tag-array reads and compares the returned entry against the request tag.
- On a miss, drives a refill handshake to the memory side, then writes the new tag back.
- Owns the invalidate-all (flush) sweep after reset and on demand.
- Sits between the fetch stage and the tag array; shares that array's gated clock.

---
 rtl/tag_lookup_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Instruction-cache tag-array sequencer: serves fetch lookups, runs the
// miss refill handshake, writes refilled tags back and sweeps the array
// clean after reset or on a flush request.
module tag_lookup_ctrl #(
    parameter int TAG_WIDTH  = 7,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BLOCKS = 4,
    parameter int BLK_SEL    = 2,
    parameter int ROW_WIDTH  = 32
) (
    input  logic                                   gated_clk,
    input  logic                                   arst_n,
    input  logic [TAG_WIDTH+ADDR_WIDTH+BLK_SEL-1:0] i_req_addr,
    input  logic                                   i_req_valid,
    output logic                                   o_req_ready,
    input  logic                                   i_flush,
    output logic                                   o_resp_valid,
    output logic                                   o_resp_hit,
    output logic                                   o_refill_valid,
    output logic [TAG_WIDTH+ADDR_WIDTH+BLK_SEL-1:0] o_refill_addr,
    input  logic                                   i_refill_ready,
    input  logic                                   i_refill_done,
    output logic [ADDR_WIDTH-1:0]                  o_ta_r_addr,
    output logic                                   o_ta_r_valid,
    output logic [TAG_WIDTH-1:0]                   o_ta_tag,
    output logic [ADDR_WIDTH-1:0]                  o_ta_w_addr,
    output logic [ROW_WIDTH-1:0]                   o_ta_w_data,
    output logic [NUM_BLOCKS-1:0]                  o_ta_w_wmask,
    output logic                                   o_ta_w_valid,
    input  logic [ROW_WIDTH-1:0]                   i_ta_data,
    input  logic                                   i_ta_valid
);

    localparam int REQ_WIDTH   = TAG_WIDTH + ADDR_WIDTH + BLK_SEL;
    localparam int ENTRY_WIDTH = TAG_WIDTH + 1;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   flush_cnt;
    logic [REQ_WIDTH-1:0]    cap_addr;

    logic [BLK_SEL-1:0]      req_blk;
    logic [ADDR_WIDTH-1:0]   req_row;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [BLK_SEL-1:0]      cap_blk;
    logic [ADDR_WIDTH-1:0]   cap_row;
    logic [TAG_WIDTH-1:0]    cap_tag;
    logic                    accept;
    logic [ENTRY_WIDTH-1:0]  entry;
    logic                    lookup_hit;
    logic [ROW_WIDTH-1:0]    fill_data;
    logic [NUM_BLOCKS-1:0]   fill_mask;

    assign req_blk = i_req_addr[BLK_SEL-1:0];
    assign req_row = i_req_addr[BLK_SEL +: ADDR_WIDTH];
    assign req_tag = i_req_addr[BLK_SEL+ADDR_WIDTH +: TAG_WIDTH];
    assign cap_blk = cap_addr[BLK_SEL-1:0];
    assign cap_row = cap_addr[BLK_SEL +: ADDR_WIDTH];
    assign cap_tag = cap_addr[BLK_SEL+ADDR_WIDTH +: TAG_WIDTH];

    // A pending flush blocks acceptance; the read must go out in the accept
    // cycle itself so the array data lines up with the LOOKUP cycle.
    assign o_req_ready  = (state == IDLE) && !i_flush;
    assign accept       = o_req_ready && i_req_valid;
    assign o_ta_r_valid = accept;
    assign o_ta_r_addr  = accept ? req_row : '0;
    assign o_ta_tag     = accept ? req_tag : '0;

    assign fill_data = {NUM_BLOCKS{{1'b1, cap_tag}}};
    assign fill_mask = NUM_BLOCKS'(1) << cap_blk;

    // Pick the block entry addressed by the captured request out of the row.
    always_comb begin
        entry = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (cap_blk == BLK_SEL'(b)) begin
                entry = i_ta_data[b*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
        lookup_hit = i_ta_valid && entry[ENTRY_WIDTH-1] &&
                     (entry[TAG_WIDTH-1:0] == cap_tag);
    end

    // Controller FSM; write drive, refill request and response are registered.
    always_ff @(posedge gated_clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= FLUSH;
            flush_cnt      <= '0;
            cap_addr       <= '0;
            o_resp_valid   <= 1'b0;
            o_resp_hit     <= 1'b0;
            o_refill_valid <= 1'b0;
            o_refill_addr  <= '0;
            o_ta_w_valid   <= 1'b1;
            o_ta_w_addr    <= '0;
            o_ta_w_data    <= '0;
            o_ta_w_wmask   <= '1;
        end else begin
            o_resp_valid <= 1'b0;
            o_resp_hit   <= 1'b0;
            case (state)
                FLUSH: begin
                    if (&flush_cnt) begin
                        state        <= IDLE;
                        flush_cnt    <= '0;
                        o_ta_w_valid <= 1'b0;
                        o_ta_w_addr  <= '0;
                        o_ta_w_wmask <= '0;
                    end else begin
                        flush_cnt   <= flush_cnt + 1'b1;
                        o_ta_w_addr <= flush_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_flush) begin
                        state        <= FLUSH;
                        flush_cnt    <= '0;
                        o_ta_w_valid <= 1'b1;
                        o_ta_w_addr  <= '0;
                        o_ta_w_data  <= '0;
                        o_ta_w_wmask <= '1;
                    end else if (i_req_valid) begin
                        cap_addr <= i_req_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        o_resp_valid <= 1'b1;
                        o_resp_hit   <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        o_refill_valid <= 1'b1;
                        o_refill_addr  <= cap_addr;
                        state          <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (i_refill_ready) begin
                        o_refill_valid <= 1'b0;
                        o_refill_addr  <= '0;
                        state          <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (i_refill_done) begin
                        state        <= FILL;
                        o_ta_w_valid <= 1'b1;
                        o_ta_w_addr  <= cap_row;
                        o_ta_w_data  <= fill_data;
                        o_ta_w_wmask <= fill_mask;
                        o_resp_valid <= 1'b1;
                        o_resp_hit   <= 1'b0;
                    end
                end
                FILL: begin
                    state        <= IDLE;
                    o_ta_w_valid <= 1'b0;
                    o_ta_w_addr  <= '0;
                    o_ta_w_data  <= '0;
                    o_ta_w_wmask <= '0;
                end
                default: begin
                    state <= FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Self-checking bench for tag_lookup_ctrl: a behavioural tag array, a
// reference cache-state model and a response scoreboard.
module tb_tag_lookup_ctrl;

    logic        gated_clk;
    logic        arst_n;
    logic [12:0] i_req_addr;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_flush;
    logic        o_resp_valid;
    logic        o_resp_hit;
    logic        o_refill_valid;
    logic [12:0] o_refill_addr;
    logic        i_refill_ready;
    logic        i_refill_done;
    logic [3:0]  o_ta_r_addr;
    logic        o_ta_r_valid;
    logic [6:0]  o_ta_tag;
    logic [3:0]  o_ta_w_addr;
    logic [31:0] o_ta_w_data;
    logic [3:0]  o_ta_w_wmask;
    logic        o_ta_w_valid;
    logic [31:0] i_ta_data;
    logic        i_ta_valid;

    typedef struct {
        bit hit;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ta_mem [16];
    bit          ref_v [16][4];
    logic [6:0]  ref_t [16][4];

    tag_lookup_ctrl dut (
        .gated_clk      (gated_clk),
        .arst_n         (arst_n),
        .i_req_addr     (i_req_addr),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_flush        (i_flush),
        .o_resp_valid   (o_resp_valid),
        .o_resp_hit     (o_resp_hit),
        .o_refill_valid (o_refill_valid),
        .o_refill_addr  (o_refill_addr),
        .i_refill_ready (i_refill_ready),
        .i_refill_done  (i_refill_done),
        .o_ta_r_addr    (o_ta_r_addr),
        .o_ta_r_valid   (o_ta_r_valid),
        .o_ta_tag       (o_ta_tag),
        .o_ta_w_addr    (o_ta_w_addr),
        .o_ta_w_data    (o_ta_w_data),
        .o_ta_w_wmask   (o_ta_w_wmask),
        .o_ta_w_valid   (o_ta_w_valid),
        .i_ta_data      (i_ta_data),
        .i_ta_valid     (i_ta_valid)
    );

    // Free-running clock.
    initial begin
        gated_clk = 1'b0;
        forever #5 gated_clk = ~gated_clk;
    end

    // Cycle counter used to measure response latency.
    always @(posedge gated_clk) cyc <= cyc + 1;

    // Behavioural tag array: one-cycle read latency, masked byte writes.
    always @(posedge gated_clk) begin
        i_ta_valid <= o_ta_r_valid;
        i_ta_data  <= o_ta_r_valid ? ta_mem[o_ta_r_addr] : 32'h0;
        if (o_ta_w_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (o_ta_w_wmask[b]) ta_mem[o_ta_w_addr][b*8 +: 8] <= o_ta_w_data[b*8 +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", name, observed, expected, cyc);
        end
    endtask

    // Response monitor: every response is popped against the scoreboard.
    always @(negedge gated_clk) begin
        if (o_resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("resp_hit", o_resp_hit, e.hit);
                if (e.hit) checkOutput("hit_latency", cyc, e.cyc);
            end
        end
    end

    task automatic clearRef();
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < 4; b++) begin
                ref_v[r][b] = 1'b0;
                ref_t[r][b] = 7'h0;
            end
    endtask

    // Called at a negedge where the sweep is about to write row 0.
    task automatic checkFlush();
        clearRef();
        for (int r = 0; r < 16; r++) begin
            checkOutput("flush_wvalid", o_ta_w_valid, 1);
            checkOutput("flush_waddr", o_ta_w_addr, r);
            checkOutput("flush_wdata", o_ta_w_data, 0);
            checkOutput("flush_wmask", o_ta_w_wmask, 4'hF);
            checkOutput("flush_ready", o_req_ready, 0);
            @(negedge gated_clk);
        end
        checkOutput("post_flush_ready", o_req_ready, 1);
        checkOutput("post_flush_wvalid", o_ta_w_valid, 0);
    endtask

    task automatic applyStimulus(input logic [12:0] addr, input int rdy_delay, input bit abort_in_wait);
        logic [6:0]  tag;
        logic [3:0]  row;
        logic [1:0]  blk;
        bit          exp_hit;
        int          n;
        int          c_acc;
        tag = addr[12:6];
        row = addr[5:2];
        blk = addr[1:0];
        @(negedge gated_clk);
        i_req_addr  = addr;
        i_req_valid = 1'b1;
        #1;
        n = 0;
        while (!o_req_ready && n < 40) begin
            @(negedge gated_clk);
            #1;
            n++;
        end
        if (!o_req_ready) begin
            checkOutput("req_timeout", 0, 1);
            i_req_valid = 1'b0;
            return;
        end
        c_acc = cyc;
        checkOutput("rd_valid", o_ta_r_valid, 1);
        checkOutput("rd_addr", o_ta_r_addr, row);
        checkOutput("rd_tag", o_ta_tag, tag);
        checkOutput("rd_wr_excl", o_ta_w_valid, 0);
        exp_hit = ref_v[row][blk] && (ref_t[row][blk] == tag);
        sb.push_back('{exp_hit, c_acc + 2});
        @(negedge gated_clk);
        i_req_valid = 1'b0;
        i_req_addr  = 13'h0;
        checkOutput("lookup_ready", o_req_ready, 0);
        @(negedge gated_clk);
        if (exp_hit) return;
        checkOutput("refill_valid", o_refill_valid, 1);
        checkOutput("refill_addr", o_refill_addr, addr);
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge gated_clk);
            checkOutput("refill_hold_valid", o_refill_valid, 1);
            checkOutput("refill_hold_addr", o_refill_addr, addr);
            checkOutput("refill_hold_nowrite", o_ta_w_valid, 0);
        end
        i_refill_ready = 1'b1;
        @(negedge gated_clk);
        i_refill_ready = 1'b0;
        checkOutput("refill_dropped", o_refill_valid, 0);
        if (abort_in_wait) begin
            arst_n = 1'b0;
            sb.delete();
            #1;
            checkOutput("abort_refill", o_refill_valid, 0);
            checkOutput("abort_resp", o_resp_valid, 0);
            checkOutput("abort_flush_w", o_ta_w_valid, 1);
            @(negedge gated_clk);
            checkOutput("abort_resp2", o_resp_valid, 0);
            arst_n = 1'b1;
            checkFlush();
            return;
        end
        @(negedge gated_clk);
        checkOutput("wait_no_resp", o_resp_valid, 0);
        i_refill_done = 1'b1;
        @(negedge gated_clk);
        i_refill_done = 1'b0;
        checkOutput("fill_wvalid", o_ta_w_valid, 1);
        checkOutput("fill_waddr", o_ta_w_addr, row);
        checkOutput("fill_wdata", o_ta_w_data, {4{1'b1, tag}});
        checkOutput("fill_wmask", o_ta_w_wmask, 4'b0001 << blk);
        ref_v[row][blk] = 1'b1;
        ref_t[row][blk] = tag;
        @(negedge gated_clk);
        checkOutput("post_fill_wvalid", o_ta_w_valid, 0);
    endtask

    // Safety net against a hung handshake.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // Main test sequence.
    initial begin
        logic [12:0] a;
        arst_n         = 1'b0;
        i_req_addr     = 13'h0;
        i_req_valid    = 1'b0;
        i_flush        = 1'b0;
        i_refill_ready = 1'b0;
        i_refill_done  = 1'b0;
        clearRef();
        repeat (3) @(negedge gated_clk);
        checkOutput("rst_resp", o_resp_valid, 0);
        checkOutput("rst_refill", o_refill_valid, 0);
        checkOutput("rst_ready", o_req_ready, 0);
        checkOutput("rst_wvalid", o_ta_w_valid, 1);
        checkOutput("rst_wmask", o_ta_w_wmask, 4'hF);
        arst_n = 1'b1;
        checkFlush();

        applyStimulus({7'h15, 4'd3, 2'd2}, 5, 1'b0);
        applyStimulus({7'h15, 4'd3, 2'd2}, 0, 1'b0);
        applyStimulus({7'h16, 4'd3, 2'd2}, 0, 1'b0);
        applyStimulus({7'h15, 4'd3, 2'd1}, 1, 1'b0);
        applyStimulus({7'h15, 4'd3, 2'd1}, 0, 1'b0);
        applyStimulus({7'h16, 4'd3, 2'd2}, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            a[12:6] = ($urandom_range(0, 1) == 0) ? 7'h2A : 7'h55;
            a[5:2]  = 4'($urandom_range(0, 1));
            a[1:0]  = 2'($urandom_range(0, 3));
            applyStimulus(a, int'($urandom_range(0, 2)), 1'b0);
        end

        @(negedge gated_clk);
        i_flush     = 1'b1;
        i_req_valid = 1'b1;
        i_req_addr  = {7'h16, 4'd3, 2'd2};
        #1;
        checkOutput("flush_wins_ready", o_req_ready, 0);
        checkOutput("flush_wins_read", o_ta_r_valid, 0);
        @(negedge gated_clk);
        i_flush     = 1'b0;
        i_req_valid = 1'b0;
        checkFlush();
        applyStimulus({7'h16, 4'd3, 2'd2}, 0, 1'b0);

        applyStimulus({7'h20, 4'd5, 2'd0}, 0, 1'b1);
        applyStimulus({7'h16, 4'd3, 2'd2}, 0, 1'b0);
        applyStimulus({7'h20, 4'd5, 2'd0}, 0, 1'b0);
        applyStimulus({7'h20, 4'd5, 2'd0}, 0, 1'b0);

        repeat (4) @(negedge gated_clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
